// File: rtl/data_mem_arb_pkg.sv
// Shared types for the two-core data-memory arbiter and its response-owner FIFO.
package data_mem_arb_pkg;

    localparam int MaxOutstandingDefault = 2;

    typedef logic owner_id_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } data_req_t;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } data_rsp_t;

endpackage

// File: rtl/data_mem_arb_if.sv
// Bundle of the per-core request/response signals and the shared data_mem port.
interface data_mem_arb_if;

    logic [1:0]        req_i;
    logic [1:0]        we_i;
    logic [1:0][3:0]   be_i;
    logic [1:0][31:0]  addr_i;
    logic [1:0][31:0]  wdata_i;
    logic [1:0]        gnt_o;
    logic [1:0]        rvalid_o;
    logic [1:0]        err_o;
    logic [1:0][31:0]  rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [31:0]       mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic              mem_err_i;
    logic [31:0]       mem_rdata_i;

    logic              protocol_err_o;

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, err_o, rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_err_i, mem_rdata_i,
        output protocol_err_o
    );

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, err_o, rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_err_i, mem_rdata_i,
        input  protocol_err_o
    );

endinterface

// File: rtl/data_mem_arb_owner_fifo.sv
// In-order FIFO of requester ids, one entry per memory request still awaiting its response.
module arb_owner_fifo
    import data_mem_arb_pkg::*;
#(
    parameter int Depth = MaxOutstandingDefault
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  owner_id_t push_id,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output owner_id_t head
);

    localparam int PtrW = $clog2(Depth) + 1;
    typedef logic [PtrW-1:0] ptr_t;
    localparam ptr_t LastSlot = ptr_t'(Depth - 1);
    localparam ptr_t DepthCount = ptr_t'(Depth);

    // Storage is sized to the pointer range so every index is in bounds; only Depth slots are used.
    owner_id_t slots [2**PtrW];
    ptr_t      wr_ptr;
    ptr_t      rd_ptr;
    ptr_t      count;
    logic      do_push;
    logic      do_pop;

    assign full    = (count == DepthCount);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LastSlot) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LastSlot) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_id;
        end
    end

endmodule

// File: rtl/data_mem_arb.sv
// Two-core arbiter for a shared data memory; responses are routed back in order via an owner FIFO.
// Define DATA_MEM_ARB_RR_EN for round-robin; otherwise core_1 (index 0) has fixed priority.
module data_mem_arb
    import data_mem_arb_pkg::*;
#(
    parameter int MaxOutstanding = MaxOutstandingDefault
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    data_mem_arb_if.slave bus
);

    data_req_t sel_req;
    data_rsp_t rsp [2];
    owner_id_t sel;
    owner_id_t sel_q;
    owner_id_t arb_sel;
    owner_id_t head;
    logic      lock_q;
    logic      lock_d;
    logic      mem_req;
    logic      accept;
    logic      pop;
    logic      full;
    logic      empty;
    logic      protocol_err_q;

`ifdef DATA_MEM_ARB_RR_EN
    owner_id_t last_gnt;
`endif

    // A request left waiting on mem_gnt keeps its requester selected until it is accepted.
    always_comb begin
        arb_sel = sel_q;
        if (bus.req_i == 2'b11) begin
`ifdef DATA_MEM_ARB_RR_EN
            arb_sel = ~last_gnt;
`else
            arb_sel = 1'b0;
`endif
        end else if (bus.req_i[0]) begin
            arb_sel = 1'b0;
        end else if (bus.req_i[1]) begin
            arb_sel = 1'b1;
        end
        sel = lock_q ? sel_q : arb_sel;
    end

    assign mem_req = bus.req_i[sel] & ~full;
    assign accept  = mem_req & bus.mem_gnt_i;
    assign pop     = bus.mem_rvalid_i & ~empty;

    always_comb begin
        lock_d = lock_q;
        if (accept) begin
            lock_d = 1'b0;
        end else if (mem_req) begin
            lock_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q          <= 1'b0;
            lock_q         <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            sel_q  <= sel;
            lock_q <= lock_d;
            if (bus.mem_rvalid_i && empty) begin
                protocol_err_q <= 1'b1;
            end
        end
    end

`ifdef DATA_MEM_ARB_RR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt <= 1'b1;
        end else if (accept) begin
            last_gnt <= sel;
        end
    end
`endif

    arb_owner_fifo #(.Depth(MaxOutstanding)) u_owner_fifo (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .push    (accept),
        .push_id (sel),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    // Every output is forced low while reset is held, independent of the clock.
    always_comb begin
        sel_req = '{we: bus.we_i[sel], be: bus.be_i[sel], addr: bus.addr_i[sel], wdata: bus.wdata_i[sel]};
        if (!rst_ni) begin
            sel_req = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rsp[i] = '0;
            if (rst_ni && pop && head == owner_id_t'(i)) begin
                rsp[i].rvalid = 1'b1;
                rsp[i].rdata  = bus.mem_rdata_i;
                rsp[i].err    = bus.mem_err_i;
            end
        end
    end

    assign bus.mem_req_o      = rst_ni & mem_req;
    assign bus.mem_we_o       = sel_req.we;
    assign bus.mem_be_o       = sel_req.be;
    assign bus.mem_addr_o     = sel_req.addr;
    assign bus.mem_wdata_o    = sel_req.wdata;
    assign bus.gnt_o          = {rst_ni & accept & sel, rst_ni & accept & ~sel};
    assign bus.protocol_err_o = protocol_err_q;

    for (genvar g = 0; g < 2; g++) begin : g_rsp
        assign bus.rvalid_o[g] = rsp[g].rvalid;
        assign bus.rdata_o[g]  = rsp[g].rdata;
        assign bus.err_o[g]    = rsp[g].err;
    end

endmodule
